// File: rtl/ahb_prior_aging_ctrl_pkg.sv
// Shared types for the dynamic-priority aging controller.
package AHB_package;

  // Per-master arbitration phase tracked by each aging cell
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OWN  = 2'd2
  } prior_age_state_e;

  // Default sizing used when the controller is instantiated without overrides
  localparam int DEF_MASTER_NUM  = 4;
  localparam int DEF_PRIOR_LEVEL = 4;
  localparam int DEF_AGE_LIMIT   = 16;

endpackage

// File: rtl/ahb_prior_aging_ctrl_if.sv
// Bus-side signal bundle between a slave arbiter and its priority controller.
interface ahb_prior_aging_ctrl_if #(
  parameter int MASTER_NUM = 4,
  parameter int PRIOR_BIT  = 2,
  parameter int IDX_BIT    = 2
);
  logic [MASTER_NUM-1:0]                hreq;
  logic [MASTER_NUM-1:0]                hgrant;
  logic [MASTER_NUM-1:0]                hlast;
  logic                                 hwait;
  logic                                 cfg_we;
  logic [IDX_BIT-1:0]                   cfg_idx;
  logic [PRIOR_BIT-1:0]                 cfg_prior;
  logic                                 cfg_age_en;
  logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] hprior;
  logic [MASTER_NUM-1:0]                starve_flag;

  // Controller side: observes the arbiter and config port, drives priorities
  modport slave (
    input  hreq, hgrant, hlast, hwait, cfg_we, cfg_idx, cfg_prior, cfg_age_en,
    output hprior, starve_flag
  );

  // Arbiter / configuration side
  modport master (
    output hreq, hgrant, hlast, hwait, cfg_we, cfg_idx, cfg_prior, cfg_age_en,
    input  hprior, starve_flag
  );
endinterface

// File: rtl/ahb_prior_age_cell.sv
// One master's aging state: FSM, wait counter, base and effective priority.
module ahb_prior_age_cell
  import AHB_package::*;
#(
  parameter int PRIOR_LEVEL = 4,
  parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
  parameter int AGE_LIMIT   = 16,
  parameter int AGE_BIT     = $clog2(AGE_LIMIT)
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 i_req,
  input  logic                 i_gnt,
  input  logic                 i_last,
  input  logic                 i_hwait,
  input  logic                 i_we,
  input  logic [PRIOR_BIT-1:0] i_cfg_prior,
  input  logic                 i_age_en,
  output logic [PRIOR_BIT-1:0] o_prior,
  output logic                 o_starve
);

  localparam logic [PRIOR_BIT-1:0] MAX_PRIOR = PRIOR_BIT'(PRIOR_LEVEL - 1);
  localparam logic [AGE_BIT-1:0]   AGE_WRAP  = AGE_BIT'(AGE_LIMIT - 1);

  prior_age_state_e     r_state;
  logic [PRIOR_BIT-1:0] r_base;
  logic [PRIOR_BIT-1:0] r_cur;
  logic [AGE_BIT-1:0]   r_cnt;
  logic                 r_starve;
  logic                 w_wrap;

  // Larger of two priority values; a write never lowers a waiting master
  function automatic logic [PRIOR_BIT-1:0] prior_max(
    input logic [PRIOR_BIT-1:0] a,
    input logic [PRIOR_BIT-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign w_wrap   = i_age_en && (r_cnt == AGE_WRAP);
  assign o_prior  = r_cur;
  assign o_starve = r_starve;

  // Phase tracking, aging and priority update; all outputs come straight from these registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state  <= IDLE;
      r_base   <= {PRIOR_BIT{1'b0}};
      r_cur    <= {PRIOR_BIT{1'b0}};
      r_cnt    <= {AGE_BIT{1'b0}};
      r_starve <= 1'b0;
    end else begin
      if (i_we) begin
        r_base <= i_cfg_prior;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= {AGE_BIT{1'b0}};
          if (i_we) begin
            r_cur <= i_cfg_prior;
          end
          if (i_req && i_gnt) begin
            r_state  <= OWN;
            r_starve <= 1'b0;
          end else if (i_req) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (i_we) begin
            r_cur <= prior_max(r_cur, i_cfg_prior);
          end
          if (i_gnt) begin
            // Grant beats a coincident wrap: no bump, aging restarts next wait
            r_state  <= OWN;
            r_cnt    <= {AGE_BIT{1'b0}};
            r_starve <= 1'b0;
          end else if (!i_req) begin
            // Aging credit in r_cur is kept until the master is actually served
            r_state <= IDLE;
            r_cnt   <= {AGE_BIT{1'b0}};
          end else if (w_wrap) begin
            r_cnt <= {AGE_BIT{1'b0}};
            // A coincident config write owns r_cur this cycle
            if (!i_we) begin
              if (r_cur == MAX_PRIOR) begin
                r_starve <= 1'b1;
              end else begin
                r_cur <= r_cur + {{(PRIOR_BIT-1){1'b0}}, 1'b1};
              end
            end
          end else if (i_age_en) begin
            r_cnt <= r_cnt + {{(AGE_BIT-1){1'b0}}, 1'b1};
          end
        end
        OWN: begin
          r_cnt <= {AGE_BIT{1'b0}};
          if (i_last && !i_hwait) begin
            r_state <= IDLE;
            // Reload from the base value that holds after this edge
            r_cur   <= i_we ? i_cfg_prior : r_base;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= {AGE_BIT{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_prior_aging_ctrl.sv
// Drives hprior of one dynamic-priority slave arbiter with starvation aging.
module ahb_prior_aging_ctrl
  import AHB_package::*;
#(
  parameter int MASTER_NUM  = DEF_MASTER_NUM,
  parameter int PRIOR_LEVEL = DEF_PRIOR_LEVEL,
  parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
  parameter int AGE_LIMIT   = DEF_AGE_LIMIT,
  parameter int AGE_BIT     = $clog2(AGE_LIMIT)
) (
  input logic             hclk,
  input logic             hreset,
  ahb_prior_aging_ctrl_if.slave bus
);

  localparam int IDX_BIT = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  logic [MASTER_NUM-1:0]                w_cell_we;
  logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] w_prior;
  logic [MASTER_NUM-1:0]                w_starve;

  assign bus.hprior      = w_prior;
  assign bus.starve_flag = w_starve;

  for (genvar g = 0; g < MASTER_NUM; g++) begin : g_cell
    // Index decode: an out-of-range cfg_idx matches no cell and is dropped
    assign w_cell_we[g] = bus.cfg_we && (bus.cfg_idx == IDX_BIT'(g));

    ahb_prior_age_cell #(
      .PRIOR_LEVEL (PRIOR_LEVEL),
      .PRIOR_BIT   (PRIOR_BIT),
      .AGE_LIMIT   (AGE_LIMIT),
      .AGE_BIT     (AGE_BIT)
    ) u_cell (
      .hclk        (hclk),
      .hreset      (hreset),
      .i_req       (bus.hreq[g]),
      .i_gnt       (bus.hgrant[g]),
      .i_last      (bus.hlast[g]),
      .i_hwait     (bus.hwait),
      .i_we        (w_cell_we[g]),
      .i_cfg_prior (bus.cfg_prior),
      .i_age_en    (bus.cfg_age_en),
      .o_prior     (w_prior[g]),
      .o_starve    (w_starve[g])
    );
  end

endmodule
